// File: rtl/plot_sched_pkg.sv
// Shared types and default widths for the VGA pixel-port scheduler.
// The PLOT_SCHED_WATCHDOG_EN macro (see plot_scheduler) does not affect this package.
package plot_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    DRAW    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int DEF_X_W = 10;
  localparam int DEF_Y_W = 10;
  localparam int DEF_C_W = 3;

endpackage

// File: rtl/plot_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
// Independent of the PLOT_SCHED_WATCHDOG_EN macro.
module plot_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             any_o,
  output logic [ID_W-1:0]  winner_o
);

  logic [ID_W:0] sum_s;

  // Walk offsets from the highest down so the smallest offset from ptr wins last
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    sum_s    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum_s = {1'b0, ptr_i} + (ID_W + 1)'(i);
      if (sum_s >= (ID_W + 1)'(N_REQ)) begin
        sum_s = sum_s - (ID_W + 1)'(N_REQ);
      end else begin
        sum_s = sum_s;
      end
      if (req_i[sum_s[ID_W-1:0]]) begin
        any_o    = 1'b1;
        winner_o = sum_s[ID_W-1:0];
      end else begin
        any_o    = any_o;
        winner_o = winner_o;
      end
    end
  end

endmodule

// File: rtl/plot_scheduler.sv
// Round-robin owner of the single VGA pixel port shared by several go/done drawers.
// Define PLOT_SCHED_WATCHDOG_EN to abort a DRAW that exceeds TIMEOUT cycles and pulse err.
module plot_scheduler
  import plot_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int C_W     = DEF_C_W,
  parameter int TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           go,
  input  logic [N_REQ-1:0]           done_in,
  input  logic [N_REQ*X_W-1:0]       x_in,
  input  logic [N_REQ*Y_W-1:0]       y_in,
  input  logic [N_REQ*C_W-1:0]       color_in,
  input  logic [N_REQ-1:0]           plot_in,
  output logic [X_W-1:0]             vga_x,
  output logic [Y_W-1:0]             vga_y,
  output logic [C_W-1:0]             vga_color,
  output logic                       vga_plot,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       err
);

  localparam int ID_W = $clog2(N_REQ);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_START   = START;
  localparam logic [1:0] ST_DRAW    = DRAW;
  localparam logic [1:0] ST_RELEASE = RELEASE;

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  gid_q, gid_d;
  logic [N_REQ-1:0] go_q, go_d;
  logic             any_s;
  logic [ID_W-1:0]  winner_s;

  plot_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .any_o    (any_s),
    .winner_o (winner_s)
  );

`ifdef PLOT_SCHED_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Next-state logic for the grant FSM
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    go_d    = '0;
`ifdef PLOT_SCHED_WATCHDOG_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          gid_d          = winner_s;
          go_d[winner_s] = 1'b1;
          state_d        = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
`ifdef PLOT_SCHED_WATCHDOG_EN
        cnt_d = '0;
`endif
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        // Only the granted drawer's done ends the job
        if (done_in[gid_q]) begin
          state_d = ST_RELEASE;
        end else begin
`ifdef PLOT_SCHED_WATCHDOG_EN
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = ST_RELEASE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          state_d = ST_DRAW;
`endif
        end
      end
      ST_RELEASE: begin
        if (gid_q == ID_W'(N_REQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = gid_q + 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      go_q    <= '0;
`ifdef PLOT_SCHED_WATCHDOG_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      go_q    <= go_d;
`ifdef PLOT_SCHED_WATCHDOG_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Zero-latency pixel mux from the granted drawer, quiet outside DRAW
  always_comb begin
    if (state_q == ST_DRAW) begin
      vga_x     = x_in[gid_q*X_W +: X_W];
      vga_y     = y_in[gid_q*Y_W +: Y_W];
      vga_color = color_in[gid_q*C_W +: C_W];
      vga_plot  = plot_in[gid_q];
    end else begin
      vga_x     = '0;
      vga_y     = '0;
      vga_color = '0;
      vga_plot  = 1'b0;
    end
  end

  assign go       = go_q;
  assign busy     = (state_q != ST_IDLE);
  assign grant_id = gid_q;

`ifdef PLOT_SCHED_WATCHDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/plot_scheduler.md
# plot_scheduler

Shares the single VGA-adapter pixel port between up to N sprite drawers (grave, soldier, background, score, …), each of which uses a go/done handshake and emits x/y/color/plot while drawing. The scheduler grants one drawer at a time in round-robin order, pulses its go, forwards its pixel stream to the adapter, and releases on done. It sits between the drawer instances and the VGA adapter in the top level.

## Interface
Parameters:
- N_REQ, 4, number of drawers (2..8)
- X_W, 10, x coordinate width
- Y_W, 10, y coordinate width
- C_W, 3, color width
- TIMEOUT, 4096, DRAW-cycle limit (used only with watchdog compiled in)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  drawer i wants the pixel port; level, held until granted
- go  out  N_REQ  one-cycle start pulse to the granted drawer
- done_in  in  N_REQ  drawer completion pulse
- x_in  in  N_REQ*X_W  packed drawer x, drawer i at [i*X_W +: X_W]
- y_in  in  N_REQ*Y_W  packed drawer y
- color_in  in  N_REQ*C_W  packed drawer color
- plot_in  in  N_REQ  drawer pixel-write strobe
- vga_x  out  X_W  to adapter
- vga_y  out  Y_W  to adapter
- vga_color  out  C_W  to adapter
- vga_plot  out  1  to adapter write enable
- busy  out  1  high in any state other than IDLE
- grant_id  out  clog2(N_REQ)  index of current/last granted drawer
- err  out  1  one-cycle timeout pulse

## Operation
- States: IDLE, START, DRAW, RELEASE.
- IDLE: if any req bit set, pick winner g by round-robin starting at ptr (first set bit at or after ptr, wrapping); latch g into grant_id; go to START. No req: stay.
- START: go[g]=1 for this cycle only; go to DRAW.
- DRAW: vga_x/y/color/plot = drawer g's x/y/color/plot (combinational mux, zero latency). done_in[g]=1 → RELEASE. Other done_in bits ignored.
- RELEASE: ptr ← (g+1) mod N_REQ; go to IDLE. Guarantees a one-cycle gap between jobs.
- Outside DRAW: vga_plot=0, vga_x/y/color=0; plot_in from any drawer ignored.
- req[g] dropping during START/DRAW does not cancel the grant; grant held until done (or timeout).
- Only one go bit ever high in any cycle.

## Timing
- Reset: state IDLE, ptr=0, grant_id=0, go=0, err=0, busy=0, all vga outputs 0. Reset mid-DRAW aborts immediately; drawer is not notified.
- req sampled high in IDLE at cycle t → go[g] high at t+1 (START) → DRAW from t+2.
- done_in[g] high at cycle d in DRAW → RELEASE at d+1 → IDLE at d+2; earliest next go at d+3.
- done_in[g] asserted during START is ignored (drawer cannot finish in zero cycles).
- Fairness: with all req held high, grant order 0,1,2,…,N_REQ-1,0,…; each job costs drawer time + 3 overhead cycles.

## Configuration
- PLOT_SCHED_WATCHDOG_EN defined: a DRAW-cycle counter clears on entry to DRAW; if it reaches TIMEOUT-1 with no done_in[g], err pulses high for one cycle and state goes to RELEASE (ptr advances normally). Counter width clog2(TIMEOUT).
- Not defined: no counter; DRAW waits indefinitely for done; err tied 0.

## Structure
- Package plot_sched_pkg: state enum (IDLE, START, DRAW, RELEASE), default width constants X_W/Y_W/C_W.
- Sub-module plot_rr_pick: combinational round-robin picker (inputs req, ptr; outputs any, winner index). Scheduler FSM, output mux and watchdog live in plot_scheduler.

## Test plan
- Reset then req=4'b0100 at cycle t → go=4'b0100 at t+1 only, grant_id=2, busy=1; drawer done after 20 cycles → busy low 2 cycles later.
- Drawer 1 in DRAW drives x=50,y=58,color=3'b111,plot=1 → vga_x=50,vga_y=58,vga_color=7,vga_plot=1 same cycle; drawer 0 plot=1 concurrently → not forwarded.
- req=4'b1111 held, each drawer done after 5 cycles → grants 0,1,2,3,0 in order, exactly one go bit per job, 3-cycle overhead each.
- done_in from non-granted drawer 3 while drawer 0 in DRAW → ignored, state stays DRAW; req[0] dropped mid-DRAW → grant retained until done_in[0].
- Reset asserted mid-DRAW → next cycle state IDLE, vga_plot=0, go=0, ptr=0.
- With PLOT_SCHED_WATCHDOG_EN, TIMEOUT=16, drawer never done → err single pulse 16 cycles after DRAW entry, next req served; without macro, busy stays high indefinitely, err=0.
